digit_row_fetch_ctrl: RTL and testbench

// Schedules a single shared 16x16 digit-glyph ROM port for an on-screen numeric readout of NUM_DIGITS digits.

---
 rtl/digit_row_fetch_ctrl.sv | 126 ++++++++++++
 tb/tb_digit_row_fetch_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_row_fetch_ctrl.sv
// Shared glyph-ROM scheduler for a NUM_DIGITS on-screen readout: fetches one glyph row
// per digit during hblank into a line buffer, then serialises it per pixel in active video.
module digit_row_fetch_ctrl #(
    parameter int NUM_DIGITS = 9,
    parameter int X0         = 16,
    parameter int Y0         = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    line_start,
    input  logic [9:0]              next_y,
    input  logic [4*NUM_DIGITS-1:0] digits_bcd,
    output logic                    rom_req,
    output logic [3:0]              rom_digit,
    output logic [3:0]              rom_row,
    input  logic [15:0]             rom_data,
    input  logic [9:0]              pix_x,
    input  logic                    pix_active,
    output logic                    pixel_on,
    output logic                    line_valid,
    output logic                    busy,
    output logic                    overrun
);

    localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW     = 4 * NUM_DIGITS;
    localparam logic [9:0] Y_LO = 10'(Y0);
    localparam logic [9:0] Y_HI = 10'(Y0 + 15);
    localparam logic [9:0] X_LO = 10'(X0);
    localparam logic [9:0] X_HI = 10'(X0 + 16 * NUM_DIGITS);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, READY} state_t;

    state_t              state;
    logic [DW-1:0]       snap;
    logic [SLOT_W-1:0]   slot;
    logic                cap_en;
    logic [SLOT_W-1:0]   cap_slot;
    logic                cap_blank;
    logic [15:0]         line_buf [NUM_DIGITS];

    logic                in_band_y;
    logic                in_band_x;
    logic [SLOT_W-1:0]   col_slot;
    logic [3:0]          col_bit;
    logic                lit;

    always_comb begin
        in_band_y = (next_y >= Y_LO) && (next_y <= Y_HI);
        in_band_x = (pix_x >= X_LO) && (pix_x < X_HI);
        col_slot  = SLOT_W'((pix_x - X_LO) >> 4);
        col_bit   = ~4'(pix_x - X_LO);
        lit       = 1'b0;
        if (in_band_x) lit = line_buf[col_slot][col_bit];
    end

    // Snapshot is consumed by shifting: the top nibble is always the next slot to issue.
    // cap_* trail rom_req by one cycle so the capture lines up with rom_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            snap       <= '0;
            slot       <= '0;
            cap_en     <= 1'b0;
            cap_slot   <= '0;
            cap_blank  <= 1'b0;
            rom_req    <= 1'b0;
            rom_digit  <= '0;
            rom_row    <= '0;
            line_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) line_buf[i] <= '0;
        end else begin
            cap_en    <= rom_req;
            cap_slot  <= slot;
            cap_blank <= (rom_digit > 4'd9);
            if (cap_en) line_buf[cap_slot] <= cap_blank ? '0 : rom_data;

            if (line_start) begin
                if (busy) overrun <= 1'b1;
                line_valid <= 1'b0;
                cap_en     <= 1'b0;
                if (in_band_y) begin
                    state     <= FETCH;
                    busy      <= 1'b1;
                    slot      <= '0;
                    rom_req   <= 1'b1;
                    rom_digit <= digits_bcd[DW-1 -: 4];
                    rom_row   <= 4'(next_y - Y_LO);
                    snap      <= digits_bcd << 4;
                end else begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    rom_req   <= 1'b0;
                end
            end else begin
                case (state)
                    FETCH: begin
                        if (slot == LAST_SLOT) begin
                            state   <= DRAIN;
                            rom_req <= 1'b0;
                        end else begin
                            slot      <= slot + 1'b1;
                            rom_digit <= snap[DW-1 -: 4];
                            snap      <= snap << 4;
                        end
                    end
                    DRAIN: begin
                        state      <= READY;
                        busy       <= 1'b0;
                        line_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pixel_on <= 1'b0;
        else        pixel_on <= line_valid & pix_active & lit;
    end

endmodule

// File: tb/tb_digit_row_fetch_ctrl.sv
// Scoreboard bench for digit_row_fetch_ctrl: ROM requests and pixel outputs are
// checked against expectations queued when the stimulus is driven.
module tb_digit_row_fetch_ctrl;

    localparam int N  = 9;
    localparam int X0 = 16;
    localparam int Y0 = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          line_start;
    logic [9:0]    next_y;
    logic [4*N-1:0] digits_bcd;
    logic          rom_req;
    logic [3:0]    rom_digit;
    logic [3:0]    rom_row;
    logic [15:0]   rom_data;
    logic [9:0]    pix_x;
    logic          pix_active;
    logic          pixel_on;
    logic          line_valid;
    logic          busy;
    logic          overrun;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  rom_q [$];
    logic        pix_q [$];
    logic [15:0] exp_buf [N];
    logic        exp_valid = 1'b0;
    logic [7:0]  rom_e;

    digit_row_fetch_ctrl #(.NUM_DIGITS(N), .X0(X0), .Y0(Y0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_start (line_start),
        .next_y     (next_y),
        .digits_bcd (digits_bcd),
        .rom_req    (rom_req),
        .rom_digit  (rom_digit),
        .rom_row    (rom_row),
        .rom_data   (rom_data),
        .pix_x      (pix_x),
        .pix_active (pix_active),
        .pixel_on   (pixel_on),
        .line_valid (line_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] glyph(input logic [3:0] d, input logic [3:0] r);
        return {d, r, ~d, r ^ 4'h5};
    endfunction

    // ROM model: word valid exactly one cycle after the request, garbage otherwise.
    always @(posedge clk) rom_data <= rom_req ? glyph(rom_digit, rom_row) : 16'hDEAD;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && rom_req === 1'b1) begin
            if (rom_q.size() == 0) check("rom_unexpected", 32'd1, 32'd0);
            else begin
                rom_e = rom_q.pop_front();
                check("rom_digit", 32'(rom_digit), 32'(rom_e[7:4]));
                check("rom_row", 32'(rom_row), 32'(rom_e[3:0]));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_line(input int y, input logic [4*N-1:0] d);
        next_y     = 10'(y);
        digits_bcd = d;
        line_start = 1'b1;
    endtask

    task automatic push_line(input int y, input logic [4*N-1:0] d);
        logic [3:0] r;
        logic [3:0] dk;
        exp_valid = 1'b0;
        if (y >= Y0 && y <= Y0 + 15) begin
            r = 4'(y - Y0);
            for (int k = 0; k < N; k++) begin
                dk = d[4*(N-1-k) +: 4];
                rom_q.push_back({dk, r});
                exp_buf[k] = (dk > 4'd9) ? 16'h0000 : glyph(dk, r);
            end
        end
    endtask

    function automatic logic exp_pix(input int x);
        int s;
        int c;
        if (!exp_valid || x < X0 || x >= X0 + 16*N) return 1'b0;
        s = (x - X0) >> 4;
        c = (x - X0) & 15;
        return exp_buf[s][15-c];
    endfunction

    task automatic sweep(input string tag);
        for (int x = X0 - 1; x <= X0 + 144; x++) begin
            pix_x      = 10'(x);
            pix_active = 1'b1;
            pix_q.push_back(exp_pix(x));
            cyc(1);
            check(tag, 32'(pixel_on), 32'(pix_q.pop_front()));
        end
        pix_active = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        line_start = 1'b0;
        next_y     = '0;
        digits_bcd = '0;
        pix_x      = '0;
        pix_active = 1'b0;
        cyc(3);
        check("rst_rom_req", 32'(rom_req), 0);
        check("rst_rom_digit", 32'(rom_digit), 0);
        check("rst_rom_row", 32'(rom_row), 0);
        check("rst_pixel_on", 32'(pixel_on), 0);
        check("rst_line_valid", 32'(line_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        rst_n = 1'b1;
        cyc(2);

        // Main fetch, digits 0..8 on row 3; inputs change after snapshot
        drive_line(Y0 + 3, 36'h012345678);
        push_line(Y0 + 3, 36'h012345678);
        cyc(1);
        line_start = 1'b0;
        check("a_req_t1", 32'(rom_req), 1);
        check("a_busy_t1", 32'(busy), 1);
        digits_bcd = 36'h999999999;
        cyc(8);
        check("a_req_t9", 32'(rom_req), 1);
        cyc(1);
        check("a_req_t10", 32'(rom_req), 0);
        check("a_busy_t10", 32'(busy), 1);
        check("a_valid_t10", 32'(line_valid), 0);
        cyc(1);
        check("a_valid_t11", 32'(line_valid), 1);
        check("a_busy_t11", 32'(busy), 0);
        check("a_rom_q_empty", 32'(rom_q.size()), 0);
        exp_valid = 1'b1;
        sweep("a_pixel_on");

        // Slot 4 holds a non-BCD code
        drive_line(Y0 + 7, 36'h0123B5678);
        push_line(Y0 + 7, 36'h0123B5678);
        cyc(1);
        line_start = 1'b0;
        cyc(10);
        check("b_valid", 32'(line_valid), 1);
        check("b_rom_q_empty", 32'(rom_q.size()), 0);
        exp_valid = 1'b1;
        sweep("b_pixel_on");

        // Line just below the glyph band
        drive_line(Y0 + 16, 36'h876543210);
        push_line(Y0 + 16, 36'h876543210);
        cyc(1);
        line_start = 1'b0;
        check("c_valid_t1", 32'(line_valid), 0);
        check("c_busy_t1", 32'(busy), 0);
        cyc(12);
        check("c_valid_late", 32'(line_valid), 0);
        sweep("c_pixel_on");

        // Second line_start at T+5 aborts and restarts
        drive_line(Y0 + 1, 36'h135792468);
        push_line(Y0 + 1, 36'h135792468);
        cyc(1);
        line_start = 1'b0;
        check("d_overrun_t1", 32'(overrun), 0);
        cyc(4);
        drive_line(Y0 + 12, 36'h864209753);
        @(negedge clk);
        #1;
        rom_q.delete();
        push_line(Y0 + 12, 36'h864209753);
        cyc(1);
        line_start = 1'b0;
        check("d_overrun_t6", 32'(overrun), 1);
        check("d_req_t6", 32'(rom_req), 1);
        cyc(8);
        check("d_req_t14", 32'(rom_req), 1);
        cyc(1);
        check("d_req_t15", 32'(rom_req), 0);
        check("d_valid_t15", 32'(line_valid), 0);
        cyc(1);
        check("d_valid_t16", 32'(line_valid), 1);
        check("d_rom_q_empty", 32'(rom_q.size()), 0);
        exp_valid = 1'b1;
        sweep("d_pixel_on");
        check("d_overrun_sticky", 32'(overrun), 1);

        // Reset asserted mid-fetch at T+4
        drive_line(Y0 + 3, 36'h012345678);
        push_line(Y0 + 3, 36'h012345678);
        cyc(1);
        line_start = 1'b0;
        cyc(3);
        #1;
        rst_n = 1'b0;
        #1;
        check("e_req", 32'(rom_req), 0);
        check("e_busy", 32'(busy), 0);
        check("e_valid", 32'(line_valid), 0);
        check("e_overrun", 32'(overrun), 0);
        check("e_rom_digit", 32'(rom_digit), 0);
        check("e_rom_row", 32'(rom_row), 0);
        rom_q.delete();
        exp_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(15);
        check("e_busy_after", 32'(busy), 0);
        check("e_valid_after", 32'(line_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
